udp_tx: RTL and testbench

UDP_TX -- requirements
Module: udp_tx

---
 rtl/udp_tx.sv | 127 ++++++++++++
 tb/tb_udp_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx.sv
// UDP transmit framer: prepends an 8-byte UDP header to a 64-bit user payload stream
// and hands the datagram to the IP layer with per-packet metadata on m_axis_ip_user.
module udp_tx #(
    parameter logic [15:0] P_SRC_UDP_PORT = 16'h8080,
    parameter logic [15:0] P_DST_UDP_PORT = 16'h8080
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_dymanic_dst_port,
    input  logic        i_dymanic_dst_valid,
    input  logic [63:0] s_axis_user_data,
    input  logic [31:0] s_axis_user_user,
    input  logic [7:0]  s_axis_user_keep,
    input  logic        s_axis_user_last,
    input  logic        s_axis_user_valid,
    output logic        s_axis_user_ready,
    output logic [63:0] m_axis_ip_data,
    output logic [55:0] m_axis_ip_user,
    output logic [7:0]  m_axis_ip_keep,
    output logic        m_axis_ip_last,
    output logic        m_axis_ip_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam logic [2:0]  C_FLAGS  = 3'b010;
    localparam logic [7:0]  C_PROTO  = 8'd17;
    localparam logic [12:0] C_OFFSET = 13'd0;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_dst_port;
    logic [15:0] r_pkt_id;
    logic [63:0] r_hold_data;
    logic [7:0]  r_hold_keep;
    logic [63:0] r_m_data;
    logic [55:0] r_m_user;
    logic [7:0]  r_m_keep;
    logic        r_m_last;
    logic        r_m_valid;

    logic        w_ready;
    logic        w_accept;
    logic [15:0] w_len_p8;

    assign w_ready  = (r_state != S_TAIL) && !i_rst;
    assign w_accept = s_axis_user_valid && w_ready;
    // Wraps modulo 2^16 by construction; the payload length is trusted as given.
    assign w_len_p8 = s_axis_user_user[15:0] + 16'd8;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = s_axis_user_last ? S_TAIL : S_DATA;
            S_DATA: if (w_accept && s_axis_user_last) w_next = S_TAIL;
            S_TAIL: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The hold register delays the payload by one beat to make room for the header.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dst_port  <= P_DST_UDP_PORT;
            r_pkt_id    <= 16'd0;
            r_hold_data <= 64'd0;
            r_hold_keep <= 8'hff;
            r_m_data    <= 64'd0;
            r_m_user    <= 56'd0;
            r_m_keep    <= 8'hff;
            r_m_last    <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            if (i_dymanic_dst_valid) r_dst_port <= i_dymanic_dst_port;

            r_m_valid <= 1'b0;
            r_m_data  <= 64'd0;
            r_m_keep  <= 8'hff;
            r_m_last  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m_valid   <= 1'b1;
                        r_m_data    <= {P_SRC_UDP_PORT, r_dst_port, w_len_p8, 16'h0000};
                        r_m_user    <= {w_len_p8, C_FLAGS, C_PROTO, C_OFFSET, r_pkt_id};
                        r_pkt_id    <= r_pkt_id + 16'd1;
                        r_hold_data <= s_axis_user_data;
                        r_hold_keep <= s_axis_user_keep;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_m_valid   <= 1'b1;
                        r_m_data    <= r_hold_data;
                        r_hold_data <= s_axis_user_data;
                        r_hold_keep <= s_axis_user_keep;
                    end
                end
                S_TAIL: begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_hold_data;
                    r_m_keep  <= r_hold_keep;
                    r_m_last  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s_axis_user_ready = w_ready;
    assign m_axis_ip_data    = r_m_data;
    assign m_axis_ip_user    = r_m_user;
    assign m_axis_ip_keep    = r_m_keep;
    assign m_axis_ip_last    = r_m_last;
    assign m_axis_ip_valid   = r_m_valid;

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: drives payload packets, collects output beats and
// compares them against hand values and a small expected-beat model.
module tb_udp_tx;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [55:0] u;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_dymanic_dst_port;
    logic        i_dymanic_dst_valid;
    logic [63:0] s_data;
    logic [31:0] s_user;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic [55:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;

    int n_chk  = 0;
    int n_fail = 0;

    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [15:0] exp_id;
    logic [15:0] exp_dst;

    always #5 i_clk = ~i_clk;

    udp_tx dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_dymanic_dst_port  (i_dymanic_dst_port),
        .i_dymanic_dst_valid (i_dymanic_dst_valid),
        .s_axis_user_data    (s_data),
        .s_axis_user_user    (s_user),
        .s_axis_user_keep    (s_keep),
        .s_axis_user_last    (s_last),
        .s_axis_user_valid   (s_valid),
        .s_axis_user_ready   (s_ready),
        .m_axis_ip_data      (m_data),
        .m_axis_ip_user      (m_user),
        .m_axis_ip_keep      (m_keep),
        .m_axis_ip_last      (m_last),
        .m_axis_ip_valid     (m_valid)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are registered, so sampling on the falling edge sees settled values.
    always @(negedge i_clk) begin
        if (m_valid === 1'b1) got_q.push_back({m_data, m_keep, m_last, m_user});
        else chk("idle_out", {m_data, m_keep, m_last}, {64'd0, 8'hff, 1'b0});
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!s_ready && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        if (!s_ready) chk("rdy_timeout", 0, 1);
    endtask

    // Sends n beats; gaps[i] inserts one idle cycle before beat i; fin marks the final
    // beat last; dyn_at pulses a destination-port update with that beat.
    task automatic send_pkt(input int n, input logic [15:0] len, input logic [7:0] lk,
                            input logic [63:0] base, input logic [31:0] gaps,
                            input bit fin, input int dyn_at);
        logic [55:0] u;
        logic [15:0] lp8;
        lp8 = len + 16'd8;
        u   = {lp8, 3'b010, 8'd17, 13'd0, exp_id};
        for (int i = 0; i < n; i++) begin
            if (gaps[i]) begin
                s_valid = 1'b0;
                @(negedge i_clk);
            end
            s_data  = base + 64'(i);
            s_user  = {16'hA5A5, len};
            s_last  = fin && (i == n - 1);
            s_keep  = s_last ? lk : 8'hff;
            s_valid = 1'b1;
            i_dymanic_dst_port  = 16'h1234;
            i_dymanic_dst_valid = (i == dyn_at);
            wait_rdy();
            @(negedge i_clk);
            i_dymanic_dst_valid = 1'b0;
            if (i == 0) begin
                exp_q.push_back({{16'h8080, exp_dst, lp8, 16'h0000}, 8'hff, 1'b0, u});
                exp_id = exp_id + 16'd1;
            end else begin
                exp_q.push_back({base + 64'(i - 1), 8'hff, 1'b0, u});
            end
            if (i == dyn_at) exp_dst = 16'h1234;
        end
        if (fin) begin
            exp_q.push_back({base + 64'(n - 1), lk, 1'b1, u});
            chk("rdy_tail", s_ready, 0);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_d"}, got_q[i].d, exp_q[i].d);
            chk({tag, "_k"}, got_q[i].k, exp_q[i].k);
            chk({tag, "_l"}, got_q[i].l, exp_q[i].l);
            chk({tag, "_u"}, got_q[i].u, exp_q[i].u);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        i_rst = 1'b1;
        i_dymanic_dst_port  = 16'h0;
        i_dymanic_dst_valid = 1'b0;
        s_data = 64'd0; s_user = 32'd0; s_keep = 8'hff; s_last = 1'b0; s_valid = 1'b0;
        exp_id  = 16'd0;
        exp_dst = 16'h8080;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_out", {m_data, m_keep, m_last}, {64'd0, 8'hff, 1'b0});
        chk("rst_user", m_user, 56'd0);
        i_rst = 1'b0;
        #1 chk("rst_rel_ready", s_ready, 1);
        @(negedge i_clk);

        // 20-byte payload in 3 beats
        send_pkt(3, 16'd20, 8'hF0, 64'h1111_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(4);
        if (got_q.size() >= 4) begin
            chk("p026_hdr", got_q[0].d, 64'h8080_8080_001C_0000);
            chk("p026_user", got_q[0].u, {16'd28, 3'b010, 8'd17, 13'd0, 16'd0});
            chk("p026_lastk", got_q[3].k, 8'hF0);
            chk("p026_last", got_q[3].l, 1);
        end
        compare("p026");

        // single-beat 8-byte payload
        send_pkt(1, 16'd8, 8'hff, 64'h2222_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(1);
        chk("p027_rdy_back", s_ready, 1);
        idle(3);
        if (got_q.size() >= 2) begin
            chk("p027_hdr", got_q[0].d, 64'h8080_8080_0010_0000);
            chk("p027_tail", {got_q[1].k, got_q[1].l}, {8'hff, 1'b1});
        end
        compare("p027");

        // back-to-back packets, valid held high across the boundary
        send_pkt(3, 16'd24, 8'hff, 64'h3333_0000_0000_0000, 32'd0, 1'b1, -1);
        send_pkt(2, 16'd12, 8'hF0, 64'h4444_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(4);
        if (got_q.size() >= 7) chk("p028_ids", {got_q[0].u[15:0], got_q[4].u[15:0]}, {16'd2, 16'd3});
        compare("p028");

        // destination port updated mid-packet
        send_pkt(4, 16'd32, 8'hff, 64'h5555_0000_0000_0000, 32'd0, 1'b1, 1);
        send_pkt(2, 16'd16, 8'hff, 64'h6666_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(4);
        if (got_q.size() >= 8) begin
            chk("p029_cur_dst", got_q[0].d[47:32], 16'h8080);
            chk("p029_nxt_dst", got_q[5].d[47:32], 16'h1234);
        end
        compare("p029");

        // valid gaps inside a 5-beat packet
        send_pkt(5, 16'd40, 8'hC0, 64'h7777_0000_0000_0000, 32'b10110, 1'b1, -1);
        idle(4);
        compare("p030");

        // reset in the middle of a packet
        send_pkt(3, 16'd40, 8'hff, 64'h8888_0000_0000_0000, 32'd0, 1'b0, -1);
        i_rst   = 1'b1;
        s_valid = 1'b0;
        #1 chk("p031_rst_ready", s_ready, 0);
        repeat (2) @(negedge i_clk);
        chk("p031_rst_valid", m_valid, 0);
        i_rst = 1'b0;
        idle(3);
        compare("p031_partial");
        exp_id  = 16'd0;
        exp_dst = 16'h8080;
        send_pkt(2, 16'd16, 8'hff, 64'h9999_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(4);
        if (got_q.size() >= 3) begin
            chk("p031_id", got_q[0].u[15:0], 16'd0);
            chk("p031_dst", got_q[0].d[47:32], 16'h8080);
        end
        compare("p031");

        // length field wraps modulo 2^16
        send_pkt(1, 16'hFFFC, 8'hff, 64'hAAAA_0000_0000_0000, 32'd0, 1'b1, -1);
        idle(4);
        if (got_q.size() >= 2) begin
            chk("wrap_hdr_len", got_q[0].d[31:16], 16'h0004);
            chk("wrap_user_len", got_q[0].u[55:40], 16'h0004);
        end
        compare("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
